qpsk_tx_mapper: RTL and testbench
=================================

Name: qpsk_tx_mapper

Overview:
- Converts a byte stream into QPSK I/Q samples for the internal input stream of the AD9363 streaming interface (its in_valid/in_data_i/in_data_q/in_ready).
- Each byte is split into 4 dibits, MSB first. Each dibit maps to one constellation point.
- Each point is repeated SPS times as signed two's-complement samples on a valid/ready stream.
- Sits directly upstream of the AD9363 stream block in the TX path.

Parameters:
- DATA_W, 12, I/Q sample width in bits (two's complement).
- SPS, 4, output samples per symbol; legal range 1..256.
- AMPL, 1024, constellation magnitude; must satisfy 0 < AMPL < 2**(DATA_W-1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset; logic is in reset when rst==0.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_last  in  1  marks final byte of a frame; sampled with s_data.
- s_ready  out  1  input byte accepted when s_valid && s_ready.
- m_valid  out  1  output sample valid.
- m_data_i  out  DATA_W  I sample.
- m_data_q  out  DATA_W  Q sample.
- m_last  out  1  high on the final sample of a byte that carried s_last.
- m_ready  in  1  downstream accepts sample when m_valid && m_ready.
- busy  out  1  high while state==SEND.

Behaviour:
- Reset (rst==0 at a clk edge) forces the following next cycle:
  - state=IDLE; sym_idx=0; rep_cnt=0; shift register=0; last flag=0.
  - m_valid=0; m_data_i=0; m_data_q=0; m_last=0; busy=0.
- Reset mid-byte discards the byte in flight; no further samples are emitted.
- States:
  - IDLE: s_ready=1. On s_valid, latch s_data and s_last, go to SEND. m_valid=1 the next cycle with dibit 0 (latency 1 cycle).
  - SEND: present the current symbol. The sample handshakes on m_valid && m_ready.
- Counters:
  - rep_cnt counts 0..SPS-1 per symbol.
  - sym_idx counts 0..3 per byte, covering dibits [7:6], [5:4], [3:2], [1:0] in that order.
  - Both advance only on a handshake. rep_cnt wraps to 0 and then sym_idx increments.
- Mapping, for dibit b1b0:
  - b1=0 -> I=+AMPL; b1=1 -> I=-AMPL.
  - b0=0 -> Q=+AMPL; b0=1 -> Q=-AMPL.
  - Negative values are two's complement in DATA_W bits, e.g. -1024 = 12'hC00.
- Final sample (sym_idx==3 && rep_cnt==SPS-1):
  - s_ready = m_valid && m_ready (combinational), allowing back-to-back bytes with no gap sample.
  - If a new byte is accepted in that cycle, stay in SEND and restart at sym_idx=0, rep_cnt=0.
  - Otherwise go to IDLE and drop m_valid next cycle.
- In SEND outside the final-sample handshake, s_ready=0.
- Backpressure: while m_valid && !m_ready, m_data_i, m_data_q and m_last hold stable and the counters freeze.
- m_last=1 only on the final sample of a byte latched with s_last=1; 0 on all other samples.
- busy=1 exactly when state==SEND.

Optional Feature:
- Macro: QPSK_IDLE_ZERO_EN.
- Defined: in IDLE (starved) the block drives m_valid=1 with m_data_i=0, m_data_q=0, m_last=0, keeping the DAC stream continuous.
  - Zero samples are consumed normally.
  - A byte accepted in IDLE replaces the zero sample starting the next cycle.
  - Reset values are unchanged; m_valid becomes 1 in the first cycle after reset release.
- Not defined: m_valid=0 in IDLE, as specified in Behaviour.

Test Plan (SPS=4, AMPL=1024, DATA_W=12):
1. Single byte 0x1B, m_ready=1 -> 16 samples starting 1 cycle after accept, in order:
   - 4x(+1024,+1024)
   - 4x(+1024,12'hC00)
   - 4x(12'hC00,+1024)
   - 4x(12'hC00,12'hC00)
   - then m_valid=0 and busy=0.
2. Bytes 0x00 then 0xFF offered continuously, m_ready=1 -> 32 contiguous valid samples with no gap:
   - 16x(+1024,+1024), then 16x(12'hC00,12'hC00).
   - s_ready high only in IDLE and in the cycle of sample 16.
3. Byte 0xE4 with m_ready toggling 1,0,1,0... -> outputs stable during every stall; exactly 16 handshaked samples with sequence I/Q = (-,-),(-,+),(+,-),(+,+), 4 each.
4. Byte 0xE4 with s_last=1 -> m_last=1 only on handshaked sample 16; a following byte with s_last=0 gives m_last=0 throughout.
5. Byte 0x1B, rst=0 after 5 handshaked samples -> next cycle m_valid=0, busy=0, s_ready=1. A new byte 0x00 then emits from dibit 0: 16x(+1024,+1024).
6. With QPSK_IDLE_ZERO_EN, no input for 10 cycles -> 10 samples (0,0) with m_valid=1. Byte 0x1B then yields the case-1 sequence starting the cycle after accept.

Source files
------------

// File: rtl/qpsk_tx_mapper.sv
// Byte-stream to QPSK I/Q sample mapper: 4 dibits per byte (MSB first), each held for SPS samples.
// Optional macro QPSK_IDLE_ZERO_EN: emit valid zero samples while starved in IDLE.
module qpsk_tx_mapper #(
    parameter int DATA_W = 12,
    parameter int SPS    = 4,
    parameter int AMPL   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data_i,
    output logic [DATA_W-1:0] m_data_q,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy
);

    // state | meaning
    // IDLE  | no byte in flight, s_ready=1
    // SEND  | presenting symbol sym_idx of the latched byte, repetition rep_cnt
    typedef enum logic {IDLE, SEND} state_t;

    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0]  REP_MAX = CNT_W'(SPS - 1);
    localparam logic [DATA_W-1:0] POS_V   = DATA_W'(AMPL);
    localparam logic [DATA_W-1:0] NEG_V   = DATA_W'(-AMPL);

    state_t           state, state_nx;
    logic [1:0]       sym_idx, sym_nx;
    logic [CNT_W-1:0] rep_cnt, rep_nx;
    logic [7:0]       shreg, shreg_nx;
    logic             last_flag, last_nx;
    logic             final_smp;
    logic             hs;

    assign final_smp = (state == SEND) && (sym_idx == 2'd3) && (rep_cnt == REP_MAX);
    assign hs        = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sym_idx   <= '0;
            rep_cnt   <= '0;
            shreg     <= '0;
            last_flag <= 1'b0;
        end else begin
            state     <= state_nx;
            sym_idx   <= sym_nx;
            rep_cnt   <= rep_nx;
            shreg     <= shreg_nx;
            last_flag <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sym_nx   = sym_idx;
        rep_nx   = rep_cnt;
        shreg_nx = shreg;
        last_nx  = last_flag;
        s_ready  = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_nx = SEND;
                    shreg_nx = s_data;
                    last_nx  = s_last;
                    sym_nx   = '0;
                    rep_nx   = '0;
                end
            end
            SEND: begin
                // Accepting during the last sample lets bytes run back to back without a gap.
                s_ready = final_smp && m_ready;
                if (hs) begin
                    if (rep_cnt == REP_MAX) begin
                        rep_nx = '0;
                        if (sym_idx == 2'd3) begin
                            if (s_valid) begin
                                shreg_nx = s_data;
                                last_nx  = s_last;
                                sym_nx   = '0;
                            end else begin
                                state_nx = IDLE;
                            end
                        end else begin
                            sym_nx   = sym_idx + 2'd1;
                            shreg_nx = {shreg[5:0], 2'b00};
                        end
                    end else begin
                        rep_nx = rep_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef QPSK_IDLE_ZERO_EN
    // Keeps m_valid low for the first cycle after reset, then IDLE emits zeros.
    logic run;
    always_ff @(posedge clk) begin
        if (!rst) run <= 1'b0;
        else      run <= 1'b1;
    end
    assign m_valid = (state == SEND) || run;
`else
    assign m_valid = (state == SEND);
`endif

    always_comb begin
        m_data_i = '0;
        m_data_q = '0;
        m_last   = 1'b0;
        if (state == SEND) begin
            m_data_i = shreg[7] ? NEG_V : POS_V;
            m_data_q = shreg[6] ? NEG_V : POS_V;
            m_last   = last_flag && final_smp;
        end
    end

    assign busy = (state == SEND);

endmodule

// File: tb/tb_qpsk_tx_mapper.sv
// Randomized and directed bench for qpsk_tx_mapper against a sample-queue reference model.
module tb_qpsk_tx_mapper;

    localparam int DATA_W = 12;
    localparam int SPS    = 4;
    localparam int AMPL   = 1024;
`ifdef QPSK_IDLE_ZERO_EN
    localparam bit IZ = 1'b1;
`else
    localparam bit IZ = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] i;
        logic [DATA_W-1:0] q;
        logic              l;
    } smp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_last;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data_i;
    logic [DATA_W-1:0] m_data_q;
    logic              m_last;
    logic              m_ready;
    logic              busy;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   checking = 1'b0;
    int   rmode = 0;
    smp_t mq[$];
    smp_t log_q[$];

    qpsk_tx_mapper #(.DATA_W(DATA_W), .SPS(SPS), .AMPL(AMPL)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data_i(m_data_i), .m_data_q(m_data_q), .m_last(m_last),
        .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] level(input bit neg);
        int v;
        v = neg ? -AMPL : AMPL;
        return v[DATA_W-1:0];
    endfunction

    // A byte becomes 4*SPS samples; the last one carries the byte's frame marker.
    task automatic push_byte(input logic [7:0] b, input logic l);
        smp_t s;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < SPS; r++) begin
                s.i = level(b[7-2*k]);
                s.q = level(b[6-2*k]);
                s.l = l && (k == 3) && (r == SPS - 1);
                mq.push_back(s);
            end
        end
    endtask

    always @(negedge clk) begin
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    bit   after_rst = 1'b1;
    bit   stall_prev = 1'b0;
    smp_t prev;

    always @(negedge clk) begin
        #2;
        if (checking) begin
            chk("m_valid", m_valid, (mq.size() > 0) || (IZ && !after_rst));
            chk("busy", busy, mq.size() > 0);
            chk("s_ready", s_ready, (mq.size() == 0) || (mq.size() == 1 && m_ready));
            if (mq.size() > 0) begin
                chk("m_data_i", m_data_i, mq[0].i);
                chk("m_data_q", m_data_q, mq[0].q);
                chk("m_last", m_last, mq[0].l);
            end else if (m_valid) begin
                chk("idle_i", m_data_i, 0);
                chk("idle_q", m_data_q, 0);
                chk("idle_last", m_last, 0);
            end
            if (stall_prev) chk("stall_hold", {m_data_i, m_data_q, m_last}, prev);
            if (!rst) begin
                mq.delete();
                after_rst  = 1'b1;
                stall_prev = 1'b0;
            end else begin
                if (m_valid && m_ready && mq.size() > 0) log_q.push_back(mq.pop_front());
                if (s_valid && s_ready) push_byte(s_data, s_last);
                after_rst  = 1'b0;
                stall_prev = m_valid && !m_ready;
                prev       = '{m_data_i, m_data_q, m_last};
            end
        end
    end

    task automatic offer(input logic [7:0] b, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = l;
        for (n = 0; n < 200; n++) begin
            #1;
            if (s_ready) break;
            @(negedge clk);
        end
        if (n == 200) chk("offer_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        if (n == 400) chk("idle_timeout", 0, 1);
    endtask

    logic [DATA_W-1:0] lit_i [4];
    logic [DATA_W-1:0] lit_q [4];
    int mark;

    task automatic chk_log(input string name, input int base, input int cnt);
        chk({name, "_count"}, log_q.size() - base, cnt);
        for (int k = 0; k < cnt && base + k < log_q.size(); k++) begin
            chk({name, "_i"}, log_q[base+k].i, lit_i[k/SPS]);
            chk({name, "_q"}, log_q[base+k].q, lit_q[k/SPS]);
        end
    endtask

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", {m_data_i, m_data_q, m_last}, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 0x1B: dibits 00,01,10,11
        lit_i = '{12'h400, 12'h400, 12'hC00, 12'hC00};
        lit_q = '{12'h400, 12'hC00, 12'h400, 12'hC00};
        mark = log_q.size();
        offer(8'h1B, 1'b0);
        s_valid = 1'b0;
        wait_idle();
        chk_log("t1", mark, 16);
        @(negedge clk); #1;
        chk("t1_end_valid", m_valid, IZ);

        // 0x00 then 0xFF back to back
        mark = log_q.size();
        offer(8'h00, 1'b0);
        offer(8'hFF, 1'b0);
        s_valid = 1'b0;
        wait_idle();
        chk("t2_count", log_q.size() - mark, 32);
        for (int k = 0; k < 32 && mark + k < log_q.size(); k++)
            chk("t2_iq", {log_q[mark+k].i, log_q[mark+k].q},
                (k < 16) ? {12'h400, 12'h400} : {12'hC00, 12'hC00});

        // 0xE4 with toggling backpressure and frame marker
        lit_i = '{12'hC00, 12'hC00, 12'h400, 12'h400};
        lit_q = '{12'hC00, 12'h400, 12'hC00, 12'h400};
        rmode = 1;
        mark = log_q.size();
        offer(8'hE4, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        chk_log("t3", mark, 16);
        for (int k = 0; k < 16 && mark + k < log_q.size(); k++)
            chk("t4_last", log_q[mark+k].l, k == 15);
        rmode = 0;
        mark = log_q.size();
        offer(8'h5A, 1'b0);
        s_valid = 1'b0;
        wait_idle();
        for (int k = 0; k < 16 && mark + k < log_q.size(); k++)
            chk("t4_nolast", log_q[mark+k].l, 0);

        // reset after 5 handshakes
        mark = log_q.size();
        offer(8'h1B, 1'b0);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_count", log_q.size() - mark, 5);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_s_ready", s_ready, 1);
        lit_i = '{12'h400, 12'h400, 12'h400, 12'h400};
        lit_q = '{12'h400, 12'h400, 12'h400, 12'h400};
        mark = log_q.size();
        offer(8'h00, 1'b0);
        s_valid = 1'b0;
        wait_idle();
        chk_log("t5", mark, 16);

        // randomized traffic with random backpressure and rare resets
        rmode = 2;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 199) != 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; rmode = 0;
        wait_idle();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
